// File: rtl/switch_pkg.sv
// Shared switch types and constants.
// Used by the VOQ read path and its skid FIFO.
package switch_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int N_IN   = 4;

  typedef logic [1:0]        port_t;
  typedef logic [ADDR_W-1:0] voq_addr_t;

  localparam logic [DATA_W-1:0] EOP_WORD = '0;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              eop;
    logic              sop;
  } skid_ent_t;
endpackage

// File: rtl/voq_skid_fifo.sv
// Small output skid FIFO holding tagged packet words.
// DEPTH must be a power of two.
module voq_skid_fifo
  import switch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  skid_ent_t     din,
  input  logic          pop,
  output skid_ent_t     head,
  output logic [CW-1:0] count
);

  skid_ent_t     mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  // storage, pointers and occupancy; clear drops everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rp];

endmodule

// File: rtl/voq_output_reader.sv
// Output-port reader: round-robin drain of the VOQ RAMs
// into a ready/valid packet stream.
module voq_output_reader
  import switch_pkg::*;
#(
  parameter int SKID_DEPTH    = 4,
  parameter int MAX_PKT_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              enable,
  input  logic [ADDR_W-1:0] wr_ptr     [N_IN],
  output logic [ADDR_W-1:0] ram_rd_add [N_IN],
  output logic              ram_rden   [N_IN],
  input  logic [DATA_W-1:0] ram_q      [N_IN],
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [1:0]        out_src,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       pkt_count,
  output logic              err_overlen
);

  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int WW = $clog2(MAX_PKT_WORDS + 1);

  rd_state_e     state;
  rd_state_e     state_n;
  port_t         gnt;
  port_t         gnt_n;
  port_t         rr;
  port_t         rr_n;
  port_t         pick;
  logic          found;
  voq_addr_t     rd_ptr [N_IN];
  logic [N_IN-1:0] ne;
  logic          ret_v;
  voq_addr_t     ret_addr;
  logic [WW-1:0] wcnt;
  logic [CW-1:0] fcount;
  skid_ent_t     head;
  skid_ent_t     din;
  logic          issue;
  logic          push;
  logic          pop;
  logic          ret_zero;
  logic          ret_max;
  logic          ret_eop;

  // per-VOQ non-empty flags and RAM read ports
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      ne[i]         = rd_ptr[i] != wr_ptr[i];
      ram_rd_add[i] = rd_ptr[i];
      ram_rden[i]   = issue && (gnt == port_t'(i));
    end
  end

  // first non-empty VOQ at or after the rr pointer
  always_comb begin
    pick  = rr;
    found = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (!found && ne[rr + port_t'(k)]) begin
        pick  = rr + port_t'(k);
        found = 1'b1;
      end
    end
  end

  // read issue, returned-word tagging and stream handshake
  always_comb begin
    out_valid = fcount != '0;
    pop       = out_valid && out_ready;
    push      = ret_v && (state == READ);
    ret_zero  = ram_q[gnt] == EOP_WORD;
    ret_max   = wcnt == WW'(MAX_PKT_WORDS - 1);
    ret_eop   = ret_zero || ret_max;
    din.data  = ram_q[gnt];
    din.eop   = ret_eop;
    din.sop   = wcnt == '0;
    issue     = (state == READ) && ne[gnt] &&
                ((int'(fcount) + int'(ret_v) - int'(pop))
                 < SKID_DEPTH);
  end

  // next-state logic for grant/read/drain
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    rr_n    = rr;
    unique case (state)
      IDLE: begin
        if (enable && found) begin
          state_n = READ;
          gnt_n   = pick;
        end
      end
      READ: begin
        if (push && ret_eop) state_n = DRAIN;
      end
      DRAIN: begin
        if (fcount == '0) begin
          state_n = IDLE;
          rr_n    = gnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state, grant and rr registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= '0;
      rr    <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      rr    <= rr_n;
    end
  end

  // read pointers: speculative advance, rewind after packet end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_IN; i++) rd_ptr[i] <= '0;
      ret_v    <= 1'b0;
      ret_addr <= '0;
      wcnt     <= '0;
    end else if (flush) begin
      for (int i = 0; i < N_IN; i++) rd_ptr[i] <= '0;
      ret_v    <= 1'b0;
      ret_addr <= '0;
      wcnt     <= '0;
    end else begin
      ret_v    <= issue;
      ret_addr <= rd_ptr[gnt];
      if (issue) rd_ptr[gnt] <= rd_ptr[gnt] + 1'b1;
      if (push && ret_eop) rd_ptr[gnt] <= ret_addr + 1'b1;
      if (state == IDLE) wcnt <= '0;
      else if (push) wcnt <= wcnt + 1'b1;
    end
  end

  // packet counter and sticky overlength flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count   <= '0;
      err_overlen <= 1'b0;
    end else if (flush) begin
      err_overlen <= 1'b0;
    end else begin
      if (state == DRAIN && fcount == '0)
        pkt_count <= pkt_count + 1'b1;
      if (push && ret_max && !ret_zero)
        err_overlen <= 1'b1;
    end
  end

  voq_skid_fifo #(
    .DEPTH(SKID_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .clear(flush),
    .push (push),
    .din  (din),
    .pop  (pop),
    .head (head),
    .count(fcount)
  );

  assign out_data = head.data;
  assign out_sop  = out_valid && head.sop;
  assign out_eop  = out_valid && head.eop;
  assign out_src  = gnt;
  assign busy     = (state != IDLE) || out_valid;

endmodule

// File: tb/tb_voq_output_reader.sv
// Directed bench for voq_output_reader with a RAM model
// and a beat scoreboard.
module tb_voq_output_reader;
  import switch_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  src;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        enable;
  logic [11:0] wr_ptr     [4];
  logic [11:0] ram_rd_add [4];
  logic        ram_rden   [4];
  logic [31:0] ram_q      [4];
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic [1:0]  out_src;
  logic        out_ready;
  logic        busy;
  logic [15:0] pkt_count;
  logic        err_overlen;

  logic [31:0] mem [4][4096];
  beat_t       sb [$];
  logic [11:0] rdlog [$];
  logic        log_rd;
  logic        bp_mon;
  logic        stall_chk;
  logic [36:0] prv;
  beat_t       exp_b;
  beat_t       cur_b;
  int          total;
  int          bad;
  int          beats;

  voq_output_reader dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .enable     (enable),
    .wr_ptr     (wr_ptr),
    .ram_rd_add (ram_rd_add),
    .ram_rden   (ram_rden),
    .ram_q      (ram_q),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .busy       (busy),
    .pkt_count  (pkt_count),
    .err_overlen(err_overlen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: one-cycle read latency
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_rden[i]) ram_q[i] <= mem[i][ram_rd_add[i]];
    if (log_rd && ram_rden[1]) rdlog.push_back(ram_rd_add[1]);
  end

  // output monitor: scoreboard, hold-while-stalled, FIFO bound
  always @(negedge clk) begin
    if (!reset || flush) begin
      stall_chk = 1'b0;
    end else begin
      cur_b = '{d: out_data, sop: out_sop,
                eop: out_eop, src: out_src};
      if (stall_chk) begin
        total++;
        assert ({out_valid, cur_b} === prv) else begin
          bad++;
          $error("FAIL hold got=%0h exp=%0h",
                 {out_valid, cur_b}, prv);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL extra_beat got=%0h exp=none", cur_b);
        end
        if (sb.size() != 0) begin
          exp_b = sb.pop_front();
          total++;
          assert (cur_b === exp_b) else begin
            bad++;
            $error("FAIL beat got=%0h exp=%0h", cur_b, exp_b);
          end
          beats++;
        end
      end
      if (bp_mon) begin
        total++;
        assert (dut.u_fifo.count <= 3'd4) else begin
          bad++;
          $error("FAIL fifo_cnt got=%0d exp<=4",
                 dut.u_fifo.count);
        end
      end
      stall_chk = out_valid && !out_ready;
      prv       = {out_valid, cur_b};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input int v, input int a, input logic [31:0] d,
                     input logic s, input logic e);
    mem[v][a % 4096] = d;
    sb.push_back('{d: d, sop: s, eop: e, src: 2'(v)});
  endtask

  task automatic wait_done(input int lim, input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(n < lim), 32'd1);
  endtask

  task automatic do_flush();
    @(posedge clk);
    #1;
    flush     = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr_ptr[i] = '0;
    sb.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    int base;
    logic [31:0] g;
    total  = 0;
    bad    = 0;
    beats  = 0;
    reset  = 1'b0;
    flush  = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    log_rd = 1'b0;
    bp_mon = 1'b0;
    stall_chk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_ptr[i] = '0;
      ram_q[i]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sop_eop", 32'({out_sop, out_eop}), 0);
    chk("rst_data", out_data, 0);
    chk("rst_src", 32'(out_src), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pkts", 32'(pkt_count), 0);
    chk("rst_err", 32'(err_overlen), 0);
    chk("rst_rden", 32'({ram_rden[0], ram_rden[1],
                         ram_rden[2], ram_rden[3]}), 0);
    chk("rst_add", 32'(ram_rd_add[2]), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // single packet in VOQ2, latency from wr_ptr update
    put(2, 0, 32'h5, 1'b1, 1'b0);
    put(2, 1, 32'hA, 1'b0, 1'b0);
    put(2, 2, 32'h0, 1'b0, 1'b1);
    wr_ptr[2] = 12'd3;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    chk("latency", lat, 3);
    wait_done(50, "single_done");
    chk("single_pkts", 32'(pkt_count), 1);
    chk("single_rdptr", 32'(dut.rd_ptr[2]), 3);

    // enable low holds off; then two packets in VOQ0
    enable = 1'b0;
    put(0, 0, 32'h1, 1'b1, 1'b0);
    put(0, 1, 32'h2, 1'b0, 1'b0);
    put(0, 2, 32'h0, 1'b0, 1'b1);
    put(0, 3, 32'h3, 1'b1, 1'b0);
    put(0, 4, 32'h4, 1'b0, 1'b0);
    put(0, 5, 32'h0, 1'b0, 1'b1);
    wr_ptr[0] = 12'd6;
    repeat (6) @(posedge clk);
    #1;
    chk("enable_hold", 32'({busy, out_valid}), 0);
    enable = 1'b1;
    wait_done(80, "b2b_done");
    chk("b2b_pkts", 32'(pkt_count), 3);
    chk("b2b_rdptr", 32'(dut.rd_ptr[0]), 6);

    // round robin from rr=1: expected order 1, 3, 0
    put(1, 0, 32'h10, 1'b1, 1'b0);
    put(1, 1, 32'h11, 1'b0, 1'b0);
    put(1, 2, 32'h0, 1'b0, 1'b1);
    put(3, 0, 32'h30, 1'b1, 1'b0);
    put(3, 1, 32'h31, 1'b0, 1'b0);
    put(3, 2, 32'h0, 1'b0, 1'b1);
    put(0, 6, 32'h70, 1'b1, 1'b0);
    put(0, 7, 32'h71, 1'b0, 1'b0);
    put(0, 8, 32'h0, 1'b0, 1'b1);
    wr_ptr[0] = 12'd9;
    wr_ptr[1] = 12'd3;
    wr_ptr[3] = 12'd3;
    wait_done(120, "rr_done");
    chk("rr_pkts", 32'(pkt_count), 6);

    // backpressure: ready toggles during a 6-word packet
    for (int k = 0; k < 5; k++)
      put(3, 3 + k, 32'h300 + 32'(k), k == 0, 1'b0);
    put(3, 8, 32'h0, 1'b0, 1'b1);
    bp_mon = 1'b1;
    out_ready = 1'b1;
    wr_ptr[3] = 12'd9;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #1;
      out_ready = ~out_ready;
      n++;
    end
    chk("bp_done", 32'(n < 200), 1);
    bp_mon = 1'b0;
    out_ready = 1'b1;
    chk("bp_pkts", 32'(pkt_count), 7);

    // overlength packets walk VOQ1 up to 4094
    do_flush();
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 1024; k++)
        put(1, p * 1024 + k, 32'h8000_0000 | (p << 16) | k,
            k == 0, k == 1023);
    for (int k = 0; k < 1022; k++)
      put(1, 3072 + k, (k == 1021) ? 32'h0 : 32'h9000_0000 | k,
          k == 0, k == 1021);
    wr_ptr[1] = 12'd4094;
    wait_done(6000, "ovl_done");
    chk("ovl_err", 32'(err_overlen), 1);
    chk("ovl_pkts", 32'(pkt_count), 11);
    chk("ovl_rdptr", 32'(dut.rd_ptr[1]), 4094);

    // packet wrapping the address space
    put(1, 4094, 32'h11, 1'b1, 1'b0);
    put(1, 4095, 32'h22, 1'b0, 1'b0);
    put(1, 0, 32'h33, 1'b0, 1'b0);
    put(1, 1, 32'h0, 1'b0, 1'b1);
    rdlog.delete();
    log_rd = 1'b1;
    wr_ptr[1] = 12'd2;
    wait_done(60, "wrap_done");
    log_rd = 1'b0;
    chk("wrap_nrd", rdlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      g = (i < rdlog.size()) ? 32'(rdlog[i]) : 32'hFFFF_FFFF;
      chk("wrap_addr", g, (4094 + i) % 4096);
    end
    chk("wrap_rdptr", 32'(dut.rd_ptr[1]), 2);
    chk("wrap_pkts", 32'(pkt_count), 12);

    // flush after two beats of a 5-word packet
    do_flush();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++)
      put(0, k, 32'h500 + 32'(k), k == 0, 1'b0);
    put(0, 4, 32'h0, 1'b0, 1'b1);
    base = beats;
    wr_ptr[0] = 12'd5;
    n = 0;
    while (beats < base + 2 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("fl_beats", 32'(n < 40), 1);
    flush     = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr_ptr[i] = '0;
    sb.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fl_valid", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++)
      chk("fl_rdptr", 32'(dut.rd_ptr[i]), 0);
    chk("fl_state", 32'(dut.state), 32'(IDLE));
    chk("fl_err", 32'(err_overlen), 0);
    chk("fl_busy", 32'(busy), 0);
    chk("fl_pkts", 32'(pkt_count), 12);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
